// File: rtl/vc_arbiter_if.sv
// rtl/vc_arbiter_if.sv - VC FIFO / destination FIFO signal bundle for vc_arbiter
interface vc_arbiter_if;
    logic       enable;
    logic       vc0_empty;
    logic       vc1_empty;
    logic [5:0] vc0_head;
    logic [5:0] vc1_head;
    logic       d0_afull;
    logic       d1_afull;
    logic       pop_vc0;
    logic       pop_vc1;
    logic       push_d0;
    logic       push_d1;
    logic [5:0] data_out;
    logic       idle_out;
    logic       active_out;
    logic [2:0] starve_cnt;

    modport master (
        input  enable, vc0_empty, vc1_empty, vc0_head, vc1_head, d0_afull, d1_afull,
        output pop_vc0, pop_vc1, push_d0, push_d1, data_out, idle_out, active_out, starve_cnt
    );

    modport slave (
        output enable, vc0_empty, vc1_empty, vc0_head, vc1_head, d0_afull, d1_afull,
        input  pop_vc0, pop_vc1, push_d0, push_d1, data_out, idle_out, active_out, starve_cnt
    );
endinterface

// File: rtl/vc_arbiter.sv
// rtl/vc_arbiter.sv - two-VC to two-destination arbiter, pop in cycle N, push in N+1
module vc_arbiter (
    input  logic            clk,
    input  logic            reset,
    vc_arbiter_if.master    bus
);
    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_ACTIVE = 2'd1;
    localparam logic [1:0] ST_STALL  = 2'd2;

    logic [1:0] state;
    logic [1:0] state_nxt;
    logic       elig0;
    logic       elig1;
    logic       grant0;
    logic       grant1;
    logic       grant;
    logic       stall_cond;
    logic       in_flight;
    logic       dest_q;
    logic [5:0] data_q;
    logic [2:0] starve_q;

    // Head bit 4 selects the destination whose almost-full gates eligibility.
    assign elig0 = bus.enable & ~bus.vc0_empty & ~(bus.vc0_head[4] ? bus.d1_afull : bus.d0_afull);
    assign elig1 = bus.enable & ~bus.vc1_empty & ~(bus.vc1_head[4] ? bus.d1_afull : bus.d0_afull);

    // Pops are combinational, so they are gated by reset to stay quiet while it is held.
    assign grant1 = reset & elig1 & (~elig0 | (starve_q == 3'd4));
    assign grant0 = reset & elig0 & ~grant1;
    assign grant  = grant0 | grant1;

    assign stall_cond = bus.enable & ~bus.vc0_empty & ~bus.vc1_empty & ~elig0 & ~elig1;

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: begin
                if (grant)
                    state_nxt = ST_ACTIVE;
            end
            ST_ACTIVE: begin
                if (grant)
                    state_nxt = ST_ACTIVE;
                else if (stall_cond)
                    state_nxt = ST_STALL;
                else if (!in_flight)
                    state_nxt = ST_IDLE;
            end
            ST_STALL: begin
                if (grant)
                    state_nxt = ST_ACTIVE;
                else if (!in_flight && ((bus.vc0_empty && bus.vc1_empty) || !bus.enable))
                    state_nxt = ST_IDLE;
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= ST_IDLE;
            in_flight <= 1'b0;
            dest_q    <= 1'b0;
            data_q    <= 6'd0;
            starve_q  <= 3'd0;
        end else begin
            state     <= state_nxt;
            in_flight <= grant;
            if (grant) begin
                data_q <= grant1 ? bus.vc1_head : bus.vc0_head;
                dest_q <= grant1 ? bus.vc1_head[4] : bus.vc0_head[4];
            end
            if (grant1 || bus.vc1_empty)
                starve_q <= 3'd0;
            else if (grant0 && (starve_q != 3'd4))
                starve_q <= starve_q + 3'd1;
        end
    end

    assign bus.pop_vc0    = grant0;
    assign bus.pop_vc1    = grant1;
    assign bus.push_d0    = in_flight & ~dest_q;
    assign bus.push_d1    = in_flight & dest_q;
    assign bus.data_out   = data_q;
    assign bus.idle_out   = (state == ST_IDLE);
    assign bus.active_out = (state == ST_ACTIVE);
    assign bus.starve_cnt = starve_q;
endmodule

// File: tb/tb_vc_arbiter.sv
// tb/tb_vc_arbiter.sv - directed self-checking bench for vc_arbiter
module tb_vc_arbiter;
    logic clk;
    logic reset;
    int   n_checks;
    int   n_pass;

    vc_arbiter_if vif ();

    vc_arbiter dut (
        .clk   (clk),
        .reset (reset),
        .bus   (vif.master)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input int got, input int exp);
        n_checks++;
        if (got == exp)
            n_pass++;
        else
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    initial begin
        int starve_exp [5];
        int rd;
        int dis_push;
        int got_q [$];

        n_checks = 0;
        n_pass   = 0;
        starve_exp = '{1, 2, 3, 4, 0};

        // Reset held with an otherwise eligible VC0 head
        reset         = 1'b0;
        vif.enable    = 1'b1;
        vif.vc0_empty = 1'b0;
        vif.vc0_head  = 6'h05;
        vif.vc1_empty = 1'b1;
        vif.vc1_head  = 6'h00;
        vif.d0_afull  = 1'b0;
        vif.d1_afull  = 1'b0;
        tick;
        tick;
        check("rst_pop0", vif.pop_vc0, 0);
        check("rst_pop1", vif.pop_vc1, 0);
        check("rst_push0", vif.push_d0, 0);
        check("rst_push1", vif.push_d1, 0);
        check("rst_data", vif.data_out, 0);
        check("rst_starve", vif.starve_cnt, 0);
        check("rst_idle", vif.idle_out, 1);
        check("rst_active", vif.active_out, 0);

        // Single VC0 word to D0
        @(negedge clk);
        reset = 1'b1;
        #1;
        check("w1_pop0", vif.pop_vc0, 1);
        check("w1_pop1", vif.pop_vc1, 0);
        tick;
        vif.vc0_empty = 1'b1;
        #1;
        check("w1_push0", vif.push_d0, 1);
        check("w1_push1", vif.push_d1, 0);
        check("w1_data", vif.data_out, 6'h05);
        check("w1_active", vif.active_out, 1);
        check("w1_nopop", vif.pop_vc0, 0);
        tick;
        check("w1_push_end", vif.push_d0, 0);
        check("w1_data_hold", vif.data_out, 6'h05);
        tick;
        check("w1_idle", vif.idle_out, 1);

        // Anti-starvation rotation: VC0 x4 then VC1
        vif.vc0_head  = 6'h01;
        vif.vc1_head  = 6'h02;
        vif.vc0_empty = 1'b0;
        vif.vc1_empty = 1'b0;
        for (int i = 0; i < 10; i++) begin
            #1;
            check($sformatf("rot%0d_pop0", i), vif.pop_vc0, (i % 5 != 4) ? 1 : 0);
            check($sformatf("rot%0d_pop1", i), vif.pop_vc1, (i % 5 == 4) ? 1 : 0);
            tick;
            check($sformatf("rot%0d_starve", i), vif.starve_cnt, starve_exp[i % 5]);
            check($sformatf("rot%0d_data", i), vif.data_out, (i % 5 == 4) ? 6'h02 : 6'h01);
            check($sformatf("rot%0d_push0", i), vif.push_d0, 1);
        end

        // VC0 blocked by d1_afull, VC1 to D0 goes first
        vif.vc0_head = 6'h12;
        vif.vc1_head = 6'h03;
        vif.d1_afull = 1'b1;
        #1;
        check("afull_pop0", vif.pop_vc0, 0);
        check("afull_pop1", vif.pop_vc1, 1);
        tick;
        vif.vc1_empty = 1'b1;
        #1;
        check("afull_push0", vif.push_d0, 1);
        check("afull_data", vif.data_out, 6'h03);
        check("afull_wait", vif.pop_vc0, 0);
        tick;
        vif.d1_afull = 1'b0;
        #1;
        check("afull_rel_pop0", vif.pop_vc0, 1);
        tick;
        vif.vc0_empty = 1'b1;
        #1;
        check("afull_push1", vif.push_d1, 1);
        check("afull_push1_d0", vif.push_d0, 0);
        check("afull_data2", vif.data_out, 6'h12);
        tick;
        tick;

        // STALL: both heads to D0, d0_afull raised after one grant
        vif.vc0_head  = 6'h01;
        vif.vc1_head  = 6'h02;
        vif.vc0_empty = 1'b0;
        vif.vc1_empty = 1'b0;
        #1;
        check("st_pop0", vif.pop_vc0, 1);
        tick;
        vif.d0_afull = 1'b1;
        #1;
        check("st_nopop0", vif.pop_vc0, 0);
        check("st_nopop1", vif.pop_vc1, 0);
        check("st_inflight_push", vif.push_d0, 1);
        tick;
        check("st_idle", vif.idle_out, 0);
        check("st_active", vif.active_out, 0);
        check("st_push_end", vif.push_d0, 0);
        tick;
        check("st_hold", vif.active_out, 0);
        vif.d0_afull = 1'b0;
        #1;
        check("st_rel_pop0", vif.pop_vc0, 1);
        tick;
        vif.vc0_empty = 1'b1;
        vif.vc1_empty = 1'b1;
        check("st_rel_active", vif.active_out, 1);
        check("st_rel_push", vif.push_d0, 1);
        tick;
        tick;

        // Reset asserted mid-delivery drops the in-flight word
        vif.vc0_head  = 6'h07;
        vif.vc0_empty = 1'b0;
        #1;
        check("mr_pop0", vif.pop_vc0, 1);
        tick;
        vif.vc0_empty = 1'b1;
        #2;
        reset = 1'b0;
        #1;
        check("mr_push0", vif.push_d0, 0);
        check("mr_data", vif.data_out, 0);
        check("mr_idle", vif.idle_out, 1);
        check("mr_active", vif.active_out, 0);
        @(negedge clk);
        reset = 1'b1;
        tick;
        check("mr_post_push0", vif.push_d0, 0);
        check("mr_post_push1", vif.push_d1, 0);
        tick;
        check("mr_post2_push0", vif.push_d0, 0);
        check("mr_post2_data", vif.data_out, 0);

        // 10-word VC0 stream with enable low for cycles 4..6
        rd       = 0;
        dis_push = 0;
        for (int c = 0; c < 30; c++) begin
            vif.enable    = !(c >= 4 && c < 7);
            vif.vc0_empty = (rd >= 10);
            vif.vc0_head  = (rd < 10) ? 6'(rd + 1) : 6'h00;
            #1;
            if (vif.push_d0) begin
                got_q.push_back(int'(vif.data_out));
                if (c >= 4 && c < 7)
                    dis_push++;
            end
            if (c >= 4 && c < 7)
                check($sformatf("en%0d_nopop", c), vif.pop_vc0, 0);
            if (c == 6)
                check("en_idle", vif.idle_out, 1);
            if (vif.pop_vc0)
                rd++;
            tick;
        end
        check("en_final_push", dis_push, 1);
        check("en_total", got_q.size(), 10);
        for (int i = 0; i < 10; i++)
            check($sformatf("en_word%0d", i), (i < got_q.size()) ? got_q[i] : -1, i + 1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
